ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  Memory-side responder for the CPU's RAM port (Enable / read_write / address / data_in / data_out).
//  Accepts one word-addressed read or write request at a time and inserts WAIT_STATES cycles.
//  Performs the access on an internal synchronous single-port array, then signals completion with a one-cycle ready pulse.
//  Serves both instruction fetch (state machine) and load/store (memory access block); the CPU holds a request until ready.
// PARAMETERS
//  ADDR_W       16            address width (word address, not byte)
//  DATA_W       32            data word width
//  DEPTH        1024          implemented words; valid addresses are 0..DEPTH-1
//  WAIT_STATES  2             extra wait cycles before the access (0..15)
// PORTS
//  clk         in   1        single clock, all logic on rising edge
//  rst_n       in   1        synchronous reset, active-low
//  Enable      in   1        request valid
//  read_write  in   1        1 = read, 0 = write
//  address     in   ADDR_W   word address
//  data_in     in   DATA_W   write data, CPU -> RAM
//  data_out    out  DATA_W   read data, RAM -> CPU
//  ready       out  1        one-cycle completion pulse
//  busy        out  1        high from accept until the cycle after ready
//  addr_err    out  1        pulses with ready when address >= DEPTH
// BEHAVIOUR
//  - FSM states: IDLE, WAIT, ACCESS, RESP.
//  - IDLE: on Enable=1, latch address/read_write/data_in and set busy.
//    - Go to WAIT with wait counter = WAIT_STATES-1, or go straight to ACCESS when WAIT_STATES=0.
//  - WAIT: decrement the counter; go to ACCESS when it reaches 0.
//  - ACCESS: drive the array.
//    - Write: array[addr] <= latched data.
//    - Read: issue the array read (1-cycle latency).
//    - Go to RESP.
//  - RESP: ready=1 for exactly one cycle.
//    - Read: data_out updates in this cycle and holds until the next read's RESP; writes never change data_out.
//    - Next state is IDLE; busy drops as RESP exits.
//  - Latency: Enable sampled at edge N -> ready high in the cycle after edge N+WAIT_STATES+2.
//  - Back-to-back: Enable high during RESP is not accepted; the next accept is at the first IDLE edge (1-cycle bubble minimum).
//  - Request fields are latched at accept. Changes to Enable, address or data_in while busy are ignored.
//    Enable dropping mid-transaction does not abort it; ready still pulses.
//  - Out of range (address >= DEPTH):
//    - Write: dropped, array unchanged.
//    - Read: returns 32'hDEAD_BEEF.
//    - Either way: addr_err=1 together with ready; same latency as an in-range access.
//  - Reset (rst_n=0 at an edge, any state): state IDLE, ready=0, busy=0, addr_err=0, data_out=0, wait counter 0.
//    - Array contents are NOT cleared.
//    - A write aborted before ACCESS leaves the array unchanged.
//    - A write in ACCESS at the reset edge is also suppressed.
//  - Outputs are registered. There are no combinational paths from inputs to outputs.
// STRUCTURE
//  - Shared package (cpu_mem_pkg):
//    - read_write encoding constants MEM_READ=1'b1, MEM_WRITE=1'b0.
//    - Responder state encoding.
//    - BAD_ADDR_DATA=32'hDEAD_BEEF.
//  - Sub-module ram_array:
//    - Synchronous single-port DEPTH x DATA_W array: we, addr, wdata, rdata.
//    - rdata is registered (1-cycle read).
//  - Top-level contents: FSM, wait counter, request latches, range check, output registers.
// TESTING
//  1. WAIT_STATES=2: write 32'h1234_5678 to addr 5 with Enable at edge 0.
//     -> ready at cycle 4, addr_err=0.
//     Then read addr 5 -> data_out=32'h1234_5678 with ready at the same relative latency.
//  2. Read addr 16'h0400 (DEPTH=1024) -> data_out=32'hDEAD_BEEF, addr_err=1 with ready.
//     Write 32'hFFFF_FFFF to 16'h0400, then read addr 0 -> addr 0 unchanged.
//  3. Hold Enable high continuously, alternating address 1, 2 -> one accept per transaction.
//     -> ready pulses spaced WAIT_STATES+3 cycles apart, never two consecutive ready cycles.
//  4. Write 32'hAAAA_AAAA to addr 7, then start a write of 32'h5555_5555 to addr 7.
//     Drop rst_n for 1 cycle during WAIT -> all outputs 0 next cycle; a following read of addr 7 returns 32'hAAAA_AAAA.
//  5. Change address and data_in and drop Enable during WAIT -> the access uses the values latched at accept, and ready still pulses.
//  6. WAIT_STATES=0 build: read request -> ready exactly 2 cycles after accept, busy high for 2 cycles.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU RAM port: request encoding, responder states
// and the data returned for reads outside the implemented range.
package cpu_mem_pkg;

   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } resp_state_e;

endpackage

// File: rtl/ram_array.sv
// Synchronous single-port word array with a registered read port.
// Contents have no reset, so they survive a responder reset.
module ram_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the CPU RAM port: latches one request, waits
// WAIT_STATES cycles, accesses the array and returns a one-cycle ready pulse.
module ram_responder
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Enable,
   input  logic              read_write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              ready,
   output logic              busy,
   output logic              addr_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   resp_state_e       state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              addr_err_q, addr_err_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [DATA_W-1:0] rdata;
   logic              array_we;

   // Gating with rst_n keeps a write in ACCESS from landing on a reset edge.
   assign array_we = rst_n && (state_q == ST_ACCESS) && (rw_q == MEM_WRITE) && !err_q;

   ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (array_we),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      busy_d     = busy_q;
      ready_d    = (state_q == ST_RESP);
      addr_err_d = (state_q == ST_RESP) && err_q;
      data_out_d = data_out_q;

      case (state_q)
         ST_IDLE: begin
            if (Enable) begin
               addr_d  = address[IDX_W-1:0];
               rw_d    = read_write;
               wdata_d = data_in;
               err_d   = ({1'b0, address} >= DEPTH_LIM);
               busy_d  = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACCESS;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            // The array read issued in ACCESS is valid now and is captured here.
            if (rw_q == MEM_READ) begin
               data_out_d = err_q ? DATA_W'(BAD_ADDR_DATA) : rdata;
            end
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         addr_err_q <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         addr_err_q <= addr_err_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;
   assign ready    = ready_q;
   assign busy     = busy_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: a WAIT_STATES=2 instance driven with
// directed and random requests against an array model, plus a WAIT_STATES=0 instance.
module tb_ram_responder;

   localparam int WS        = 2;
   localparam int EXP_LAT   = WS + 2;
   localparam int EXP_BUSY  = WS + 2;
   localparam int DEPTH     = 1024;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;
   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        enable = 1'b0, rw = 1'b0;
   logic [15:0] addr = '0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        ready, busy, aerr;

   logic        z_enable = 1'b0, z_rw = 1'b0;
   logic [15:0] z_addr = '0;
   logic [31:0] z_din = '0;
   logic [31:0] z_dout;
   logic        z_ready, z_busy, z_aerr;

   int errors = 0;
   int checks = 0;

   logic [31:0] model_mem [DEPTH];
   bit          model_valid [DEPTH];
   logic [31:0] model_dout = '0;

   always #5 clk = ~clk;

   ram_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst_n(rst_n), .Enable(enable), .read_write(rw), .address(addr),
      .data_in(din), .data_out(dout), .ready(ready), .busy(busy), .addr_err(aerr)
   );

   ram_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .Enable(z_enable), .read_write(z_rw), .address(z_addr),
      .data_in(z_din), .data_out(z_dout), .ready(z_ready), .busy(z_busy), .addr_err(z_aerr)
   );

   // Reference model: what a completed transaction leaves behind.
   task automatic model_apply(input logic r, input logic [15:0] a, input logic [31:0] d,
                              output logic [31:0] exp_dout, output logic exp_err);
      exp_err = (a >= 16'(DEPTH));
      if (r == RD) begin
         model_dout = exp_err ? BAD : model_mem[a[9:0]];
      end else if (!exp_err) begin
         model_mem[a[9:0]]   = d;
         model_valid[a[9:0]] = 1'b1;
      end
      exp_dout = model_dout;
   endtask

   // Issues one request from IDLE and returns what was seen in the ready cycle.
   task automatic run_txn(input logic r, input logic [15:0] a, input logic [31:0] d,
                          input bit scramble, output int lat, output int busy_cnt,
                          output logic [31:0] dout_o, output logic aerr_o);
      enable = 1'b1; rw = r; addr = a; din = d;
      @(posedge clk); #1;
      enable = 1'b0;
      if (scramble) begin
         addr = a + 16'd1;
         din  = ~d;
         rw   = ~r;
      end
      lat = -1;
      busy_cnt = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (ready) begin
            lat = k;
            break;
         end
         if (busy) busy_cnt++;
      end
      dout_o = dout;
      aerr_o = aerr;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({ready, busy, aerr} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {ready, busy, aerr}); end
      checks++; if (dout !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00000000", dout); end
      checks++; if ({z_ready, z_busy, z_aerr} !== 3'b000 || z_dout !== 32'h0) begin errors++; $display("[TB] FAIL reset_zero_ws: got %b/%h expected 000/00000000", {z_ready, z_busy, z_aerr}, z_dout); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int lat, bc; logic [31:0] o, ed; logic e, ee;
      model_apply(WR, 16'd5, 32'h1234_5678, ed, ee);
      run_txn(WR, 16'd5, 32'h1234_5678, 1'b0, lat, bc, o, e);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL wr5_latency: got %0d expected %0d", lat, EXP_LAT); end
      checks++; if (bc !== EXP_BUSY) begin errors++; $display("[TB] FAIL wr5_busy: got %0d expected %0d", bc, EXP_BUSY); end
      checks++; if (e !== ee || o !== ed) begin errors++; $display("[TB] FAIL wr5_outputs: got err=%b dout=%h expected err=%b dout=%h", e, o, ee, ed); end
      @(posedge clk); #1;
      checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wr5_single_pulse: got ready=%b busy=%b expected 0 0", ready, busy); end
      model_apply(RD, 16'd5, 32'h0, ed, ee);
      run_txn(RD, 16'd5, 32'h0, 1'b0, lat, bc, o, e);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL rd5_latency: got %0d expected %0d", lat, EXP_LAT); end
      checks++; if (o !== 32'h1234_5678 || e !== 1'b0) begin errors++; $display("[TB] FAIL rd5_data: got %h err=%b expected 12345678 err=0", o, e); end
   endtask

   task automatic test_out_of_range();
      int lat, bc; logic [31:0] o, ed; logic e, ee;
      model_apply(WR, 16'd0, 32'h0F0F_0001, ed, ee);
      run_txn(WR, 16'd0, 32'h0F0F_0001, 1'b0, lat, bc, o, e);
      model_apply(RD, 16'h0400, 32'h0, ed, ee);
      run_txn(RD, 16'h0400, 32'h0, 1'b0, lat, bc, o, e);
      checks++; if (o !== BAD || e !== 1'b1) begin errors++; $display("[TB] FAIL oor_read: got %h err=%b expected deadbeef err=1", o, e); end
      checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL oor_latency: got %0d expected %0d", lat, EXP_LAT); end
      model_apply(WR, 16'h0400, 32'hFFFF_FFFF, ed, ee);
      run_txn(WR, 16'h0400, 32'hFFFF_FFFF, 1'b0, lat, bc, o, e);
      checks++; if (e !== 1'b1 || o !== ed) begin errors++; $display("[TB] FAIL oor_write: got err=%b dout=%h expected err=1 dout=%h", e, o, ed); end
      model_apply(RD, 16'd0, 32'h0, ed, ee);
      run_txn(RD, 16'd0, 32'h0, 1'b0, lat, bc, o, e);
      checks++; if (o !== 32'h0F0F_0001 || e !== 1'b0) begin errors++; $display("[TB] FAIL oor_addr0_intact: got %h err=%b expected 0f0f0001 err=0", o, e); end
   endtask

   task automatic test_back_to_back();
      int lat, bc, last, pulses, n_cyc; logic [31:0] o, ed; logic e, ee, prev;
      model_apply(WR, 16'd1, 32'h1111_0001, ed, ee);
      run_txn(WR, 16'd1, 32'h1111_0001, 1'b0, lat, bc, o, e);
      model_apply(WR, 16'd2, 32'h2222_0002, ed, ee);
      run_txn(WR, 16'd2, 32'h2222_0002, 1'b0, lat, bc, o, e);
      n_cyc = 30; pulses = 0; last = 0; prev = 1'b0;
      enable = 1'b1; rw = RD; addr = 16'd1;
      for (int k = 1; k <= n_cyc; k++) begin
         @(posedge clk); #1;
         if (ready) begin
            checks++; if (prev) begin errors++; $display("[TB] FAIL b2b_consecutive: got ready in cycle %0d after ready, expected gap", k); end
            checks++; if ((pulses == 0 && k !== WS + 3) || (pulses > 0 && k - last !== WS + 3)) begin errors++; $display("[TB] FAIL b2b_spacing: got pulse at %0d (previous %0d) expected spacing %0d", k, last, WS + 3); end
            model_apply(RD, addr, 32'h0, ed, ee);
            checks++; if (dout !== ed) begin errors++; $display("[TB] FAIL b2b_data: got %h expected %h", dout, ed); end
            pulses++; last = k;
            addr = (addr == 16'd1) ? 16'd2 : 16'd1;
         end
         prev = ready;
      end
      enable = 1'b0;
      checks++; if (pulses !== (n_cyc - (WS + 3)) / (WS + 3) + 1) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", pulses, (n_cyc - (WS + 3)) / (WS + 3) + 1); end
      repeat (WS + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort();
      int lat, bc; logic [31:0] o, ed; logic e, ee;
      model_apply(WR, 16'd7, 32'hAAAA_AAAA, ed, ee);
      run_txn(WR, 16'd7, 32'hAAAA_AAAA, 1'b0, lat, bc, o, e);
      enable = 1'b1; rw = WR; addr = 16'd7; din = 32'h5555_5555;
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_dout = 32'h0;
      checks++; if ({ready, busy, aerr} !== 3'b000 || dout !== 32'h0) begin errors++; $display("[TB] FAIL abort_wait_outputs: got %b/%h expected 000/00000000", {ready, busy, aerr}, dout); end
      model_apply(RD, 16'd7, 32'h0, ed, ee);
      run_txn(RD, 16'd7, 32'h0, 1'b0, lat, bc, o, e);
      checks++; if (o !== 32'hAAAA_AAAA) begin errors++; $display("[TB] FAIL abort_wait_mem: got %h expected aaaaaaaa", o); end
      enable = 1'b1; rw = WR; addr = 16'd7; din = 32'h5555_5555;
      @(posedge clk); #1;
      enable = 1'b0;
      repeat (WS) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_dout = 32'h0;
      run_txn(RD, 16'd7, 32'h0, 1'b0, lat, bc, o, e);
      checks++; if (o !== 32'hAAAA_AAAA) begin errors++; $display("[TB] FAIL abort_access_mem: got %h expected aaaaaaaa", o); end
   endtask

   task automatic test_latched_fields();
      int lat, bc; logic [31:0] o, ed; logic e, ee;
      model_apply(WR, 16'd11, 32'h1111_1111, ed, ee);
      run_txn(WR, 16'd11, 32'h1111_1111, 1'b0, lat, bc, o, e);
      model_apply(WR, 16'd10, 32'hCAFE_0010, ed, ee);
      run_txn(WR, 16'd10, 32'hCAFE_0010, 1'b1, lat, bc, o, e);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL latch_ready: got latency %0d expected %0d", lat, EXP_LAT); end
      model_apply(RD, 16'd10, 32'h0, ed, ee);
      run_txn(RD, 16'd10, 32'h0, 1'b1, lat, bc, o, e);
      checks++; if (o !== 32'hCAFE_0010) begin errors++; $display("[TB] FAIL latch_addr10: got %h expected cafe0010", o); end
      model_apply(RD, 16'd11, 32'h0, ed, ee);
      run_txn(RD, 16'd11, 32'h0, 1'b0, lat, bc, o, e);
      checks++; if (o !== 32'h1111_1111) begin errors++; $display("[TB] FAIL latch_addr11: got %h expected 11111111", o); end
   endtask

   task automatic test_random();
      int lat, bc; logic [31:0] o, ed; logic e, ee;
      for (int i = 0; i < 24; i++) begin
         logic [15:0] a; logic r; logic [31:0] d;
         if ($urandom_range(0, 9) == 0) a = 16'(DEPTH + $urandom_range(0, 60000));
         else a = 16'($urandom_range(0, 31));
         r = 1'($urandom_range(0, 1));
         if (r == RD && a < 16'(DEPTH) && !model_valid[a[9:0]]) r = WR;
         d = $urandom;
         model_apply(r, a, d, ed, ee);
         run_txn(r, a, d, 1'b0, lat, bc, o, e);
         checks++; if (lat !== EXP_LAT || bc !== EXP_BUSY) begin errors++; $display("[TB] FAIL rand_timing[%0d]: got lat=%0d busy=%0d expected %0d %0d", i, lat, bc, EXP_LAT, EXP_BUSY); end
         checks++; if (o !== ed || e !== ee) begin errors++; $display("[TB] FAIL rand_result[%0d]: got %h err=%b expected %h err=%b (rw=%b addr=%h)", i, o, e, ed, ee, r, a); end
      end
   endtask

   task automatic test_zero_wait();
      int lat, bc;
      for (int t = 0; t < 2; t++) begin
         z_enable = 1'b1; z_rw = (t == 0) ? WR : RD; z_addr = 16'd3; z_din = 32'h0BAD_F00D;
         @(posedge clk); #1;
         z_enable = 1'b0;
         lat = -1;
         bc = z_busy ? 1 : 0;
         for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (z_ready) begin
               lat = k;
               break;
            end
            if (z_busy) bc++;
         end
         checks++; if (lat !== 2 || bc !== 2) begin errors++; $display("[TB] FAIL zero_ws_timing[%0d]: got lat=%0d busy=%0d expected 2 2", t, lat, bc); end
         checks++; if (z_aerr !== 1'b0 || z_dout !== ((t == 0) ? 32'h0 : 32'h0BAD_F00D)) begin errors++; $display("[TB] FAIL zero_ws_data[%0d]: got %h err=%b", t, z_dout, z_aerr); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i]   = 32'h0;
         model_valid[i] = 1'b0;
      end
      test_reset();
      test_write_read();
      test_out_of_range();
      test_back_to_back();
      test_reset_abort();
      test_latched_fields();
      test_random();
      test_zero_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
